// File: rtl/pool_window_feeder.sv
// Raster-stream to 2x2 window converter feeding the max-pooling unit.
// Buffers one even row and emits non-overlapping stride-2 windows with a valid/ready handshake.
module pool_window_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] win_tl,
  output logic [DATA_W-1:0] win_tr,
  output logic [DATA_W-1:0] win_bl,
  output logic [DATA_W-1:0] win_br,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last,
  output logic              frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [DATA_W-1:0] linebuf_q [IMG_W];
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] tl_q, tl_d, tr_q, tr_d, bl_q, bl_d, br_q, br_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              odd_row, odd_col;
  logic              col_end, row_end;
  logic              load_win;
  logic [ColW-1:0]   col_pair;

  // A stalled window blocks input on every row so counters and buffers stay frozen.
  assign in_ready = ~win_valid_q | win_ready;
  assign accept   = in_valid & in_ready;
  assign odd_row  = row_q[0];
  assign odd_col  = col_q[0];
  assign col_end  = (col_q == ColLast);
  assign row_end  = (row_q == RowLast);
  assign load_win = accept & odd_row & odd_col;
  assign col_pair = col_q & ~ColW'(1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    tl_d        = tl_q;
    tr_d        = tr_q;
    bl_d        = bl_q;
    br_d        = br_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (load_win) begin
      // Reload wins over a same-cycle downstream accept, keeping full throughput.
      tl_d        = linebuf_q[col_pair];
      tr_d        = linebuf_q[col_q];
      bl_d        = hold_q;
      br_d        = in_data;
      win_valid_d = 1'b1;
      win_last_d  = row_end & col_end;
    end else if (win_valid_q & win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    frame_done_d = win_valid_q & win_ready & win_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      tl_q         <= '0;
      tr_q         <= '0;
      bl_q         <= '0;
      br_q         <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      tl_q         <= tl_d;
      tr_q         <= tr_d;
      bl_q         <= bl_d;
      br_q         <= br_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Data storage needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (accept && !odd_row) begin
      linebuf_q[col_q] <= in_data;
    end
    if (accept && odd_row && !odd_col) begin
      hold_q <= in_data;
    end
  end

  assign win_tl     = tl_q;
  assign win_tr     = tr_q;
  assign win_bl     = bl_q;
  assign win_br     = br_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder: table-driven frames, hand-written corner sequences
// and random frames/backpressure checked against a frame-level window model.
module tb_pool_window_feeder;

  localparam int unsigned DW   = 16;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NWIN = NPIX / 4;

  typedef logic [NPIX-1:0][DW-1:0] frame_t;
  typedef struct packed {
    logic [DW-1:0] tl;
    logic [DW-1:0] tr;
    logic [DW-1:0] bl;
    logic [DW-1:0] br;
    logic          last;
  } win_t;
  typedef struct packed {
    frame_t              pix;
    win_t [NWIN-1:0]     w;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] win_tl, win_tr, win_bl, win_br;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic          win_last;
  logic          frame_done;

  pool_window_feeder #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_tl    (win_tl),
    .win_tr    (win_tr),
    .win_bl    (win_bl),
    .win_br    (win_br),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  win_t exp_q[$];
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit   expect_done = 1'b0;
  bit   prev_stall = 1'b0;
  win_t held;
  win_t exp_w;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic win_t mkw(input logic [DW-1:0] tl, tr, bl, br, input logic last);
    return {tl, tr, bl, br, last};
  endfunction

  // Reference: window (r,c) takes rows 2r/2r+1, cols 2c/2c+1 of the frame, row-major order.
  function automatic void push_model(input frame_t f);
    for (int r = 0; r < int'(H / 2); r++) begin
      for (int c = 0; c < int'(W / 2); c++) begin
        exp_q.push_back(mkw(f[(2*r)*W + 2*c], f[(2*r)*W + 2*c + 1],
                            f[(2*r+1)*W + 2*c], f[(2*r+1)*W + 2*c + 1],
                            (r == int'(H / 2) - 1) && (c == int'(W / 2) - 1)));
      end
    end
  endfunction

  function automatic void push_table(input vec_t v);
    for (int i = 0; i < int'(NWIN); i++) exp_q.push_back(v.w[i]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       win_ready = 1'($urandom_range(0, 1));
        2:       win_ready = 1'b0;
        default: win_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      expect_done = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(expect_done));
      check("in_ready", 32'(in_ready), 32'(!win_valid || win_ready));
      if (prev_stall && win_valid) begin
        check("stall_tl", 32'(win_tl), 32'(held.tl));
        check("stall_tr", 32'(win_tr), 32'(held.tr));
        check("stall_bl", 32'(win_bl), 32'(held.bl));
        check("stall_br", 32'(win_br), 32'(held.br));
        check("stall_last", 32'(win_last), 32'(held.last));
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %h %h %h %h required none",
                   win_tl, win_tr, win_bl, win_br);
        end else begin
          exp_w = exp_q.pop_front();
          check("win_tl", 32'(win_tl), 32'(exp_w.tl));
          check("win_tr", 32'(win_tr), 32'(exp_w.tr));
          check("win_bl", 32'(win_bl), 32'(exp_w.bl));
          check("win_br", 32'(win_br), 32'(exp_w.br));
          check("win_last", 32'(win_last), 32'(exp_w.last));
        end
      end
      expect_done = win_valid && win_ready && win_last;
      prev_stall  = win_valid && !win_ready;
      held        = {win_tl, win_tr, win_bl, win_br, win_last};
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit gaps);
    bit done;
    done = 1'b0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input frame_t f, input bit gaps);
    for (int i = 0; i < int'(NPIX); i++) send(f[i], gaps);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || win_valid); k++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_win_last", 32'(win_last), 32'd0);
    check("rst_win_tl", 32'(win_tl), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_win_valid", 32'(win_valid), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic bp_seq();
    for (int k = 0; k < 100 && !win_valid; k++) @(negedge clk);
    check("bp_window_seen", 32'(win_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_tl", 32'(win_tl), 32'(vecs[0].w[0].tl));
      check("bp_br", 32'(win_br), 32'(vecs[0].w[0].br));
    end
    ready_mode = 0;
  endtask

  initial begin
    frame_t fa, fb;

    // Ramp, descending-from-0x8000, and signed-edge frames with hand-derived windows.
    for (int i = 0; i < int'(NPIX); i++) begin
      vecs[0].pix[i] = DW'(i);
      vecs[1].pix[i] = DW'(16'h8000 - i);
      vecs[2].pix[i] = DW'(i);
    end
    vecs[0].w[0] = mkw(16'd0, 16'd1, 16'd4, 16'd5, 1'b0);
    vecs[0].w[1] = mkw(16'd2, 16'd3, 16'd6, 16'd7, 1'b0);
    vecs[0].w[2] = mkw(16'd8, 16'd9, 16'd12, 16'd13, 1'b0);
    vecs[0].w[3] = mkw(16'd10, 16'd11, 16'd14, 16'd15, 1'b1);
    vecs[1].w[0] = mkw(16'h8000, 16'h7FFF, 16'h7FFC, 16'h7FFB, 1'b0);
    vecs[1].w[1] = mkw(16'h7FFE, 16'h7FFD, 16'h7FFA, 16'h7FF9, 1'b0);
    vecs[1].w[2] = mkw(16'h7FF8, 16'h7FF7, 16'h7FF4, 16'h7FF3, 1'b0);
    vecs[1].w[3] = mkw(16'h7FF6, 16'h7FF5, 16'h7FF2, 16'h7FF1, 1'b1);
    vecs[2].pix[0] = 16'hE003;
    vecs[2].pix[1] = 16'hFFFF;
    vecs[2].pix[2] = 16'h0001;
    vecs[2].pix[3] = 16'h8000;
    vecs[2].pix[4] = 16'hFFFE;
    vecs[2].pix[5] = 16'hFFFC;
    vecs[2].pix[6] = 16'h7FFF;
    vecs[2].pix[7] = 16'h0000;
    vecs[2].w[0] = mkw(16'hE003, 16'hFFFF, 16'hFFFE, 16'hFFFC, 1'b0);
    vecs[2].w[1] = mkw(16'h0001, 16'h8000, 16'h7FFF, 16'h0000, 1'b0);
    vecs[2].w[2] = mkw(16'd8, 16'd9, 16'd12, 16'd13, 1'b0);
    vecs[2].w[3] = mkw(16'd10, 16'd11, 16'd14, 16'd15, 1'b1);

    do_reset();

    for (int v = 0; v < 3; v++) begin
      push_table(vecs[v]);
      stream(vecs[v].pix, 1'b0);
      drain();
    end

    // Backpressure held for 5 cycles on the first window.
    push_table(vecs[0]);
    ready_mode = 2;
    fork
      stream(vecs[0].pix, 1'b0);
      bp_seq();
    join
    drain();

    push_table(vecs[0]);
    stream(vecs[0].pix, 1'b1);
    drain();

    // Abort a frame after pixel 9, then a clean frame must follow.
    exp_q.push_back(vecs[0].w[0]);
    exp_q.push_back(vecs[0].w[1]);
    for (int i = 0; i < 10; i++) send(vecs[0].pix[i], 1'b0);
    drain();
    do_reset();
    push_table(vecs[0]);
    stream(vecs[0].pix, 1'b0);
    drain();

    // Back-to-back random frames with no idle cycle between them.
    for (int i = 0; i < int'(NPIX); i++) begin
      fa[i] = DW'($urandom);
      fb[i] = DW'($urandom);
    end
    push_model(fa);
    push_model(fb);
    stream(fa, 1'b0);
    stream(fb, 1'b0);
    drain();

    ready_mode = 1;
    repeat (6) begin
      for (int i = 0; i < int'(NPIX); i++) fa[i] = DW'($urandom);
      push_model(fa);
      stream(fa, 1'b1);
    end
    ready_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
